// File: rtl/mc_ctrl_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the LAB_1 single-issue 32-bit datapath.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (undefined opcodes trap to ERR instead of NOP).
module mc_ctrl_unit #(
  parameter int OPW         = 6,
  parameter int ACK_TIMEOUT = 255,
  parameter int TCW         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        ir_load,
  output logic        datasrc,
  output logic [3:0]  alu_op,
  input  logic        alu_zero,
  output logic        rf_we,
  output logic        rf_dst_rt,
  output logic        mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       datasrc;
    logic [3:0] alu_op;
    logic       rf_we;
    logic       rf_dst_rt;
    logic       mem_to_reg;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_inc;
    logic       pc_load;
    logic       halted;
    logic       err;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(2);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(3);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4);
  localparam logic [OPW-1:0] OP_SW   = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_J    = OPW'(7);
  localparam logic [OPW-1:0] OP_HALT = {OPW{1'b1}};

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [3:0]     funct_q, funct_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  ctrl_t          ctrl_q, ctrl_d;

  logic is_r, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt;
  logic is_itype, is_legal;
  logic unused_instr;

  assign unused_instr = ^instr[31-OPW:4];

  // op_d equals op_q except on the fetch-ack edge, so one decoder serves both
  // next-state selection and the registered outputs of the state being entered.
  assign is_r     = (op_d == OP_R);
  assign is_addi  = (op_d == OP_ADDI);
  assign is_andi  = (op_d == OP_ANDI);
  assign is_ori   = (op_d == OP_ORI);
  assign is_lw    = (op_d == OP_LW);
  assign is_sw    = (op_d == OP_SW);
  assign is_beq   = (op_d == OP_BEQ);
  assign is_j     = (op_d == OP_J);
  assign is_halt  = (op_d == OP_HALT);
  assign is_itype = is_addi | is_andi | is_ori;
  assign is_legal = is_r | is_itype | is_lw | is_sw | is_beq | is_j | is_halt;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          op_d    = instr[31 -: OPW];
          funct_d = instr[3:0];
          state_d = S_DECODE;
        end else if (tmo_q == TCW'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_j)            state_d = S_FETCH;
        else if (is_halt)    state_d = S_HALT;
        else if (!is_legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = S_ERR;
`else
          state_d = S_FETCH;
`endif
        end else             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_beq)    state_d = S_FETCH;
        else                state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)                             state_d = is_sw ? S_FETCH : S_WB;
        else if (tmo_q == TCW'(ACK_TIMEOUT - 1))  state_d = S_ERR;
        else                                      tmo_d   = tmo_q + 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered, so each
  // strobe is glitch-free and aligned with the cycle of that state.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: ctrl_d.imem_req = 1'b1;
      S_EXEC, S_MEM, S_WB: begin
        ctrl_d.datasrc = is_itype | is_lw | is_sw;
        ctrl_d.alu_op  = is_r    ? funct_d :
                         is_andi ? 4'b0010 :
                         is_ori  ? 4'b0011 :
                         is_beq  ? 4'b0001 : 4'b0000;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      S_ERR:   ctrl_d.err    = 1'b1;
      default: ;
    endcase
    if (state_d == S_MEM) begin
      ctrl_d.dmem_req = 1'b1;
      ctrl_d.dmem_we  = is_sw;
    end
    if (state_d == S_WB) begin
      ctrl_d.rf_we      = 1'b1;
      ctrl_d.rf_dst_rt  = is_itype | is_lw;
      ctrl_d.mem_to_reg = is_lw;
    end
    if (state_q == S_FETCH && state_d == S_DECODE) begin
      ctrl_d.ir_load = 1'b1;
      ctrl_d.pc_inc  = 1'b1;
    end
    // A jump asserts pc_inc and pc_load together in DECODE; the datapath gives pc_load priority.
    if (state_d == S_DECODE && is_j)                  ctrl_d.pc_load = 1'b1;
    if (state_q == S_EXEC && is_beq && alu_zero)      ctrl_d.pc_load = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      funct_q <= '0;
      tmo_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      tmo_q   <= tmo_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign imem_req   = ctrl_q.imem_req;
  assign ir_load    = ctrl_q.ir_load;
  assign datasrc    = ctrl_q.datasrc;
  assign alu_op     = ctrl_q.alu_op;
  assign rf_we      = ctrl_q.rf_we;
  assign rf_dst_rt  = ctrl_q.rf_dst_rt;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign dmem_req   = ctrl_q.dmem_req;
  assign dmem_we    = ctrl_q.dmem_we;
  assign pc_inc     = ctrl_q.pc_inc;
  assign pc_load    = ctrl_q.pc_load;
  assign halted     = ctrl_q.halted;
  assign err        = ctrl_q.err;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed-vector bench for mc_ctrl_unit: per-cycle expected output words written by hand.
module tb_mc_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] instr = '0;

  logic       imem_req, ir_load, datasrc, rf_we, rf_dst_rt, mem_to_reg;
  logic       dmem_req, dmem_we, pc_inc, pc_load, halted, err;
  logic [3:0] alu_op;

  mc_ctrl_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .ir_load    (ir_load),
    .datasrc    (datasrc),
    .alu_op     (alu_op),
    .alu_zero   (alu_zero),
    .rf_we      (rf_we),
    .rf_dst_rt  (rf_dst_rt),
    .mem_to_reg (mem_to_reg),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Output word: {imem_req, ir_load, datasrc, alu_op[3:0], rf_we, rf_dst_rt,
  //               mem_to_reg, dmem_req, dmem_we, pc_inc, pc_load, halted, err}
  logic [15:0] outs;
  assign outs = {imem_req, ir_load, datasrc, alu_op, rf_we, rf_dst_rt,
                 mem_to_reg, dmem_req, dmem_we, pc_inc, pc_load, halted, err};

  localparam logic [15:0] IREQ = 16'h8000;
  localparam logic [15:0] IRL  = 16'h4000;
  localparam logic [15:0] DS   = 16'h2000;
  localparam logic [15:0] WE   = 16'h0100;
  localparam logic [15:0] RT   = 16'h0080;
  localparam logic [15:0] M2R  = 16'h0040;
  localparam logic [15:0] DREQ = 16'h0020;
  localparam logic [15:0] DWE  = 16'h0010;
  localparam logic [15:0] INC  = 16'h0008;
  localparam logic [15:0] PCL  = 16'h0004;
  localparam logic [15:0] HLT  = 16'h0002;
  localparam logic [15:0] ERRB = 16'h0001;

  function automatic logic [15:0] alu(input logic [3:0] op);
    return {3'b000, op, 9'b0};
  endfunction

  typedef struct packed {
    logic [15:0] o;
    logic        dack;
    logic        zero;
  } step_t;

  step_t seq[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: outputs=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [15:0] o, input logic dack, input logic zero);
    seq.push_back('{o: o, dack: dack, zero: zero});
  endtask

  // Called while the DUT sits in FETCH: acks ins, then checks one queued word per cycle
  // and drives that entry's dmem_ack/alu_zero during the same cycle.
  task automatic run_seq(input string tag, input logic [31:0] ins);
    imem_ack = 1'b1;
    instr    = ins;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), outs, seq[i].o);
      dmem_ack = seq[i].dack;
      alu_zero = seq[i].zero;
      if (i < seq.size() - 1) tick();
    end
    seq.delete();
  endtask

  task automatic do_reset(input string tag);
    start    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    alu_zero = 1'b0;
    instr    = '0;
    rst_n    = 1'b0;
    #2;
    check({tag, "_async"}, outs, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check({tag, "_idle"}, outs, 16'h0000);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_entry", outs, IREQ);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    do_reset("por");
    tick();
    check("idle_hold", outs, 16'h0000);
    do_start();

    // ADDI: 4 cycles ack-to-FETCH, I-type write to rt
    add(IRL | INC, 1'b0, 1'b0);
    add(DS | alu(4'h0), 1'b0, 1'b0);
    add(DS | alu(4'h0) | WE | RT, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("addi", 32'h0401_0005);

    // R-type funct=0010
    add(IRL | INC, 1'b0, 1'b0);
    add(alu(4'h2), 1'b0, 1'b0);
    add(alu(4'h2) | WE, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("rtype", 32'h0043_0802);

    // LW with dmem_ack arriving on the fourth MEM cycle
    add(IRL | INC, 1'b0, 1'b0);
    add(DS, 1'b0, 1'b0);
    add(DS | DREQ, 1'b0, 1'b0);
    add(DS | DREQ, 1'b0, 1'b0);
    add(DS | DREQ, 1'b0, 1'b0);
    add(DS | DREQ, 1'b1, 1'b0);
    add(DS | WE | RT | M2R, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("lw_wait", 32'h1041_0008);

    // SW, with spurious dmem_ack held high through DECODE and EXEC
    add(IRL | INC, 1'b1, 1'b0);
    add(DS, 1'b1, 1'b0);
    add(DS | DREQ | DWE, 1'b1, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("sw", 32'h1441_0008);

    // BEQ taken: single pc_load pulse on the cycle after EXEC
    add(IRL | INC, 1'b0, 1'b1);
    add(alu(4'h1), 1'b0, 1'b1);
    add(IREQ | PCL, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("beq_taken", 32'h1843_0004);

    // BEQ not taken
    add(IRL | INC, 1'b0, 1'b0);
    add(alu(4'h1), 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("beq_not", 32'h1843_0004);

    // J: pc_load in DECODE, 2 cycles
    add(IRL | INC | PCL, 1'b0, 1'b0);
    add(IREQ, 1'b0, 1'b0);
    run_seq("jump", 32'h1C00_0010);

    // Undefined opcode 001010
    add(IRL | INC, 1'b0, 1'b0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    add(ERRB, 1'b0, 1'b0);
    add(ERRB, 1'b0, 1'b0);
    run_seq("illegal_trap", 32'h2800_0000);
    do_reset("after_trap");
    do_start();
`else
    add(IREQ, 1'b0, 1'b0);
    run_seq("illegal_nop", 32'h2800_0000);
`endif

    // HALT: sticky, start and spurious acks ignored
    add(IRL | INC, 1'b0, 1'b0);
    add(HLT, 1'b0, 1'b0);
    run_seq("halt", 32'hFC00_0000);
    start    = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (3) tick();
    check("halt_sticky", outs, HLT);

    // Fetch timeout: 255 waiting cycles in FETCH, then ERR
    do_reset("pre_tmo");
    do_start();
    repeat (254) tick();
    check("tmo_last_wait", outs, IREQ);
    tick();
    check("tmo_err", outs, ERRB);
    start    = 1'b1;
    imem_ack = 1'b1;
    repeat (3) tick();
    check("err_sticky", outs, ERRB);

    // Reset in the middle of a fetch
    do_reset("clr_err");
    do_start();
    repeat (2) tick();
    check("fetch_wait", outs, IREQ);
    do_reset("rst_mid_fetch");

    // Reset with a load parked in MEM: no write-back afterwards
    do_start();
    imem_ack = 1'b1;
    instr    = 32'h1041_0008;
    tick();
    imem_ack = 1'b0;
    repeat (2) tick();
    check("lw_mem_pre_rst", outs, DS | DREQ);
    do_reset("rst_mid_mem");
    dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_idle[%0d]", i), outs, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
